// File: rtl/riscv_pkg.sv
// Shared RV32I pipeline types: ALU control codes, decoder op classes and
// forwarding source selects.
package riscv_pkg;

  typedef enum logic [3:0] {
    AC_AND = 4'b0000,
    AC_OR  = 4'b0001,
    AC_ADD = 4'b0010,
    AC_XOR = 4'b0011,
    AC_SLL = 4'b0100,
    AC_SRL = 4'b0101,
    AC_SUB = 4'b0110,
    AC_SRA = 4'b0111,
    AC_NOP = 4'b1000
  } alu_ctrl_e;

  typedef enum logic [1:0] {
    OP_MEM    = 2'b00,
    OP_BRANCH = 2'b01,
    OP_RTYPE  = 2'b10,
    OP_ITYPE  = 2'b11
  } alu_op_e;

  typedef enum logic [1:0] {
    FWD_REG = 2'b00,
    FWD_WB  = 2'b01,
    FWD_EXM = 2'b10
  } fwd_sel_e;

  localparam logic [3:0] ALU_NOP = 4'b1000;

endpackage

// File: rtl/alu_ctrl_dec.sv
// ALU control decoder: maps alu_op/funct3/funct7b5 to a 4-bit ALU code.
// funct3 010/011 (slt/sltu) decode to NOP with the illegal flag set.
module alu_ctrl_dec
  import riscv_pkg::*;
(
  input  alu_op_e    alu_op,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  output alu_ctrl_e  alu_ctrl,
  output logic       illegal
);

  // Decode the operation class, then funct3 for R/I-type arithmetic.
  always_comb begin
    alu_ctrl = AC_NOP;
    illegal  = 1'b0;
    case (alu_op)
      OP_MEM:    alu_ctrl = AC_ADD;
      OP_BRANCH: alu_ctrl = AC_SUB;
      OP_RTYPE, OP_ITYPE: begin
        case (funct3)
          3'b000: begin
            // Immediate forms have no subtract; bit 30 is part of the imm.
            if ((alu_op == OP_RTYPE) && funct7b5) begin
              alu_ctrl = AC_SUB;
            end else begin
              alu_ctrl = AC_ADD;
            end
          end
          3'b001: alu_ctrl = AC_SLL;
          3'b100: alu_ctrl = AC_XOR;
          3'b101: begin
            if (funct7b5) begin
              alu_ctrl = AC_SRA;
            end else begin
              alu_ctrl = AC_SRL;
            end
          end
          3'b110: alu_ctrl = AC_OR;
          3'b111: alu_ctrl = AC_AND;
          default: begin
            alu_ctrl = AC_NOP;
            illegal  = 1'b1;
          end
        endcase
      end
      default: begin
        alu_ctrl = AC_NOP;
        illegal  = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with ALU-control decode, load-use bubble
// insertion, held-operand refresh and EX/MEM / MEM/WB operand forwarding.
module id_ex_stage
  import riscv_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int REG_AW = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic              flush,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic [XLEN-1:0]   id_rs1_data,
  input  logic [XLEN-1:0]   id_rs2_data,
  input  logic [XLEN-1:0]   id_imm,
  input  logic [REG_AW-1:0] id_rd,
  input  logic [1:0]        id_alu_op,
  input  logic [2:0]        id_funct3,
  input  logic              id_funct7b5,
  input  logic              id_alu_src,
  input  logic              id_reg_write,
  input  logic              id_mem_read,
  input  logic              id_mem_write,
  input  logic              id_mem_to_reg,
  input  logic              exm_reg_write,
  input  logic [REG_AW-1:0] exm_rd,
  input  logic [XLEN-1:0]   exm_result,
  input  logic              wb_reg_write,
  input  logic [REG_AW-1:0] wb_rd,
  input  logic [XLEN-1:0]   wb_data,
  output logic              load_use,
  output logic              ex_valid,
  output logic [XLEN-1:0]   ex_a,
  output logic [XLEN-1:0]   ex_b,
  output logic [3:0]        ex_alu_ctrl,
  output logic [XLEN-1:0]   ex_store_data,
  output logic [REG_AW-1:0] ex_rd,
  output logic              ex_reg_write,
  output logic              ex_mem_read,
  output logic              ex_mem_write,
  output logic              ex_mem_to_reg,
  output logic              ex_illegal
);

  localparam logic [REG_AW-1:0] REG_ZERO  = {REG_AW{1'b0}};
  localparam logic [XLEN-1:0]   DATA_ZERO = {XLEN{1'b0}};

  logic              valid_q, valid_d;
  logic [REG_AW-1:0] rs1_q, rs1_d, rs2_q, rs2_d, rd_q, rd_d;
  logic [XLEN-1:0]   rs1_data_q, rs1_data_d, rs2_data_q, rs2_data_d;
  logic [XLEN-1:0]   imm_q, imm_d;
  logic              alu_src_q, alu_src_d;
  logic              reg_write_q, reg_write_d, mem_read_q, mem_read_d;
  logic              mem_write_q, mem_write_d, mem_to_reg_q, mem_to_reg_d;
  logic [3:0]        alu_ctrl_q, alu_ctrl_d;
  logic              illegal_q, illegal_d;

  alu_ctrl_e         dec_ctrl;
  logic              dec_illegal;
  logic              hazard_lu;
  fwd_sel_e          sel_a, sel_b;
  logic [XLEN-1:0]   fwd_rs1, fwd_rs2;

  alu_ctrl_dec u_alu_ctrl_dec (
    .alu_op   (alu_op_e'(id_alu_op)),
    .funct3   (id_funct3),
    .funct7b5 (id_funct7b5),
    .alu_ctrl (dec_ctrl),
    .illegal  (dec_illegal)
  );

  // Most recent producer wins; register x0 is hard-wired and never forwards.
  function automatic fwd_sel_e fwd_pick(input logic [REG_AW-1:0] rs,
                                        input logic exm_we, input logic [REG_AW-1:0] exm_idx,
                                        input logic wb_we, input logic [REG_AW-1:0] wb_idx);
    fwd_sel_e sel;
    if ((rs != REG_ZERO) && exm_we && (exm_idx == rs)) begin
      sel = FWD_EXM;
    end else if ((rs != REG_ZERO) && wb_we && (wb_idx == rs)) begin
      sel = FWD_WB;
    end else begin
      sel = FWD_REG;
    end
    return sel;
  endfunction

  // Load in EX whose destination is read by the instruction in ID.
  always_comb begin
    hazard_lu = valid_q & mem_read_q & (rd_q != REG_ZERO) &
                ((rd_q == id_rs1) | (rd_q == id_rs2)) & id_valid;
  end

  // Next-state selection: flush, then stall (with WB refresh), then bubble, then capture.
  always_comb begin
    valid_d = valid_q;  rs1_d = rs1_q;  rs2_d = rs2_q;  rd_d = rd_q;
    rs1_data_d = rs1_data_q;  rs2_data_d = rs2_data_q;  imm_d = imm_q;
    alu_src_d = alu_src_q;  reg_write_d = reg_write_q;  mem_read_d = mem_read_q;
    mem_write_d = mem_write_q;  mem_to_reg_d = mem_to_reg_q;
    alu_ctrl_d = alu_ctrl_q;  illegal_d = illegal_q;
    if (flush || (!stall && hazard_lu)) begin
      valid_d = 1'b0;  rs1_d = REG_ZERO;  rs2_d = REG_ZERO;  rd_d = REG_ZERO;
      rs1_data_d = DATA_ZERO;  rs2_data_d = DATA_ZERO;  imm_d = DATA_ZERO;
      alu_src_d = 1'b0;  reg_write_d = 1'b0;  mem_read_d = 1'b0;
      mem_write_d = 1'b0;  mem_to_reg_d = 1'b0;
      alu_ctrl_d = ALU_NOP;  illegal_d = 1'b0;
    end else if (stall) begin
      // A register retiring in WB during the hold would otherwise be lost.
      if (wb_reg_write && (wb_rd != REG_ZERO) && (wb_rd == rs1_q)) begin
        rs1_data_d = wb_data;
      end else begin
        rs1_data_d = rs1_data_q;
      end
      if (wb_reg_write && (wb_rd != REG_ZERO) && (wb_rd == rs2_q)) begin
        rs2_data_d = wb_data;
      end else begin
        rs2_data_d = rs2_data_q;
      end
    end else begin
      valid_d = id_valid;  rs1_d = id_rs1;  rs2_d = id_rs2;  rd_d = id_rd;
      rs1_data_d = id_rs1_data;  rs2_data_d = id_rs2_data;  imm_d = id_imm;
      alu_src_d = id_alu_src;  reg_write_d = id_reg_write;  mem_read_d = id_mem_read;
      mem_write_d = id_mem_write;  mem_to_reg_d = id_mem_to_reg;
      alu_ctrl_d = dec_ctrl;  illegal_d = dec_illegal;
    end
  end

  // ID/EX state register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;  rs1_q <= REG_ZERO;  rs2_q <= REG_ZERO;  rd_q <= REG_ZERO;
      rs1_data_q <= DATA_ZERO;  rs2_data_q <= DATA_ZERO;  imm_q <= DATA_ZERO;
      alu_src_q <= 1'b0;  reg_write_q <= 1'b0;  mem_read_q <= 1'b0;
      mem_write_q <= 1'b0;  mem_to_reg_q <= 1'b0;
      alu_ctrl_q <= ALU_NOP;  illegal_q <= 1'b0;
    end else begin
      valid_q <= valid_d;  rs1_q <= rs1_d;  rs2_q <= rs2_d;  rd_q <= rd_d;
      rs1_data_q <= rs1_data_d;  rs2_data_q <= rs2_data_d;  imm_q <= imm_d;
      alu_src_q <= alu_src_d;  reg_write_q <= reg_write_d;  mem_read_q <= mem_read_d;
      mem_write_q <= mem_write_d;  mem_to_reg_q <= mem_to_reg_d;
      alu_ctrl_q <= alu_ctrl_d;  illegal_q <= illegal_d;
    end
  end

  // Same-cycle operand forwarding from the registered source indices.
  always_comb begin
    sel_a = fwd_pick(rs1_q, exm_reg_write, exm_rd, wb_reg_write, wb_rd);
    sel_b = fwd_pick(rs2_q, exm_reg_write, exm_rd, wb_reg_write, wb_rd);
    case (sel_a)
      FWD_EXM: fwd_rs1 = exm_result;
      FWD_WB:  fwd_rs1 = wb_data;
      default: fwd_rs1 = rs1_data_q;
    endcase
    case (sel_b)
      FWD_EXM: fwd_rs2 = exm_result;
      FWD_WB:  fwd_rs2 = wb_data;
      default: fwd_rs2 = rs2_data_q;
    endcase
  end

  assign load_use      = hazard_lu;
  assign ex_valid      = valid_q;
  assign ex_a          = fwd_rs1;
  assign ex_b          = alu_src_q ? imm_q : fwd_rs2;
  assign ex_store_data = fwd_rs2;
  assign ex_alu_ctrl   = alu_ctrl_q;
  assign ex_rd         = rd_q;
  assign ex_reg_write  = reg_write_q;
  assign ex_mem_read   = mem_read_q;
  assign ex_mem_write  = mem_write_q;
  assign ex_mem_to_reg = mem_to_reg_q;
  assign ex_illegal    = illegal_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Self-checking bench for id_ex_stage: directed scenarios plus randomized
// traffic against a behavioural model of the EX slot.
module tb_id_ex_stage;

  logic        clk = 1'b0;
  logic        rst, stall, flush, id_valid;
  logic [4:0]  id_rs1, id_rs2, id_rd, exm_rd, wb_rd;
  logic [31:0] id_rs1_data, id_rs2_data, id_imm, exm_result, wb_data;
  logic [1:0]  id_alu_op;
  logic [2:0]  id_funct3;
  logic        id_funct7b5, id_alu_src, id_reg_write, id_mem_read, id_mem_write, id_mem_to_reg;
  logic        exm_reg_write, wb_reg_write;
  logic        load_use, ex_valid, ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg, ex_illegal;
  logic [31:0] ex_a, ex_b, ex_store_data;
  logic [3:0]  ex_alu_ctrl;
  logic [4:0]  ex_rd;

  int errors = 0;
  int checks = 0;

  // Behavioural model of what the EX slot should hold.
  logic        m_valid, m_src, m_rw, m_mr, m_mw, m_m2r, m_ill;
  logic [4:0]  m_rs1, m_rs2, m_rd;
  logic [31:0] m_d1, m_d2, m_imm;
  logic [3:0]  m_ctrl;

  always #5 clk = ~clk;

  id_ex_stage dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush), .id_valid(id_valid),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data),
    .id_imm(id_imm), .id_rd(id_rd), .id_alu_op(id_alu_op), .id_funct3(id_funct3),
    .id_funct7b5(id_funct7b5), .id_alu_src(id_alu_src), .id_reg_write(id_reg_write),
    .id_mem_read(id_mem_read), .id_mem_write(id_mem_write), .id_mem_to_reg(id_mem_to_reg),
    .exm_reg_write(exm_reg_write), .exm_rd(exm_rd), .exm_result(exm_result),
    .wb_reg_write(wb_reg_write), .wb_rd(wb_rd), .wb_data(wb_data),
    .load_use(load_use), .ex_valid(ex_valid), .ex_a(ex_a), .ex_b(ex_b),
    .ex_alu_ctrl(ex_alu_ctrl), .ex_store_data(ex_store_data), .ex_rd(ex_rd),
    .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
    .ex_mem_to_reg(ex_mem_to_reg), .ex_illegal(ex_illegal)
  );

  // Expected ALU code from the instruction-level rules.
  function automatic void exp_dec(input logic [1:0] op, input logic [2:0] f3, input logic b5,
                                  output logic [3:0] c, output logic ill);
    logic [3:0] by_f3 [8];
    by_f3[0] = 4'b0010; by_f3[1] = 4'b0100; by_f3[2] = 4'b1000; by_f3[3] = 4'b1000;
    by_f3[4] = 4'b0011; by_f3[5] = 4'b0101; by_f3[6] = 4'b0001; by_f3[7] = 4'b0000;
    ill = 1'b0;
    if (op == 2'b00) c = 4'b0010;
    else if (op == 2'b01) c = 4'b0110;
    else begin
      c = by_f3[f3];
      if (f3 == 3'b010 || f3 == 3'b011) ill = 1'b1;
      if (b5 && f3 == 3'b000 && op == 2'b10) c = 4'b0110;
      if (b5 && f3 == 3'b101) c = 4'b0111;
    end
  endfunction

  function automatic logic [31:0] exp_fwd(input logic [4:0] rs, input logic [31:0] stored);
    if (rs != 5'd0 && exm_reg_write && exm_rd == rs) return exm_result;
    if (rs != 5'd0 && wb_reg_write && wb_rd == rs) return wb_data;
    return stored;
  endfunction

  function automatic logic model_lu();
    return m_valid && m_mr && (m_rd != 5'd0) && (m_rd == id_rs1 || m_rd == id_rs2) && id_valid;
  endfunction

  task automatic model_bubble();
    m_valid = 1'b0; m_rw = 1'b0; m_mr = 1'b0; m_mw = 1'b0; m_m2r = 1'b0;
    m_ill = 1'b0; m_ctrl = 4'b1000;
  endtask

  // Advance the model from the current inputs, then clock the DUT.
  task automatic tick();
    logic lu;
    lu = model_lu();
    if (rst) begin
      model_bubble();
      m_rs1 = 5'd0; m_rs2 = 5'd0; m_rd = 5'd0; m_d1 = 32'd0; m_d2 = 32'd0; m_imm = 32'd0; m_src = 1'b0;
    end else if (flush) model_bubble();
    else if (stall) begin
      if (wb_reg_write && wb_rd != 5'd0 && wb_rd == m_rs1) m_d1 = wb_data;
      if (wb_reg_write && wb_rd != 5'd0 && wb_rd == m_rs2) m_d2 = wb_data;
    end else if (lu) model_bubble();
    else begin
      m_valid = id_valid; m_rs1 = id_rs1; m_rs2 = id_rs2; m_rd = id_rd;
      m_d1 = id_rs1_data; m_d2 = id_rs2_data; m_imm = id_imm; m_src = id_alu_src;
      m_rw = id_reg_write; m_mr = id_mem_read; m_mw = id_mem_write; m_m2r = id_mem_to_reg;
      exp_dec(id_alu_op, id_funct3, id_funct7b5, m_ctrl, m_ill);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    stall = 1'b0; flush = 1'b0; id_valid = 1'b0; id_rs1 = 5'd0; id_rs2 = 5'd0; id_rd = 5'd0;
    id_rs1_data = 32'd0; id_rs2_data = 32'd0; id_imm = 32'd0; id_alu_op = 2'b00; id_funct3 = 3'b000;
    id_funct7b5 = 1'b0; id_alu_src = 1'b0; id_reg_write = 1'b0; id_mem_read = 1'b0;
    id_mem_write = 1'b0; id_mem_to_reg = 1'b0; exm_reg_write = 1'b0; exm_rd = 5'd0;
    exm_result = 32'd0; wb_reg_write = 1'b0; wb_rd = 5'd0; wb_data = 32'd0;
  endtask

  task automatic set_id(input logic [1:0] op, input logic [2:0] f3, input logic b5,
                        input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                        input logic [31:0] d1, input logic [31:0] d2, input logic [31:0] imm,
                        input logic src, input logic mr);
    id_valid = 1'b1; id_alu_op = op; id_funct3 = f3; id_funct7b5 = b5; id_rs1 = rs1; id_rs2 = rs2;
    id_rd = rd; id_rs1_data = d1; id_rs2_data = d2; id_imm = imm; id_alu_src = src;
    id_mem_read = mr; id_mem_to_reg = mr; id_reg_write = 1'b1; id_mem_write = 1'b0;
  endtask

  task automatic test_reset();
    clear_inputs();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    #1;
    checks++;
    if ({ex_valid, ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg, ex_illegal, load_use} !== 7'b0) begin
      errors++; $display("FAIL reset_flags got=%b want=0", {ex_valid, ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg, ex_illegal, load_use});
    end
    checks++;
    if (ex_alu_ctrl !== 4'b1000) begin errors++; $display("FAIL reset_ctrl got=%b want=1000", ex_alu_ctrl); end
    checks++;
    if ({ex_a, ex_b, ex_store_data, ex_rd} !== 101'd0) begin
      errors++; $display("FAIL reset_data a=%h b=%h st=%h rd=%0d want all 0", ex_a, ex_b, ex_store_data, ex_rd);
    end
  endtask

  task automatic test_decode();
    set_id(2'b10, 3'b000, 1'b0, 5'd1, 5'd2, 5'd6, 32'd5, 32'd7, 32'd0, 1'b0, 1'b0);
    tick();
    checks++;
    if (ex_alu_ctrl !== 4'b0010 || ex_a !== 32'd5 || ex_b !== 32'd7 || ex_valid !== 1'b1) begin
      errors++; $display("FAIL add_rtype ctrl=%b a=%0d b=%0d v=%b want 0010/5/7/1", ex_alu_ctrl, ex_a, ex_b, ex_valid);
    end
    set_id(2'b11, 3'b101, 1'b1, 5'd1, 5'd2, 5'd6, 32'd40, 32'd9, 32'd3, 1'b1, 1'b0);
    tick();
    checks++;
    if (ex_alu_ctrl !== 4'b0111 || ex_b !== 32'd3) begin
      errors++; $display("FAIL srai ctrl=%b b=%0d want 0111/3", ex_alu_ctrl, ex_b);
    end
    set_id(2'b11, 3'b000, 1'b1, 5'd1, 5'd2, 5'd6, 32'd1, 32'd1, 32'd1, 1'b1, 1'b0);
    tick();
    checks++;
    if (ex_alu_ctrl !== 4'b0010) begin errors++; $display("FAIL addi_b5 ctrl=%b want 0010", ex_alu_ctrl); end
    set_id(2'b10, 3'b010, 1'b0, 5'd1, 5'd2, 5'd6, 32'd1, 32'd1, 32'd0, 1'b0, 1'b0);
    tick();
    checks++;
    if (ex_alu_ctrl !== 4'b1000 || ex_illegal !== 1'b1 || ex_valid !== 1'b1) begin
      errors++; $display("FAIL slt_illegal ctrl=%b ill=%b v=%b want 1000/1/1", ex_alu_ctrl, ex_illegal, ex_valid);
    end
  endtask

  task automatic test_forwarding();
    set_id(2'b00, 3'b000, 1'b0, 5'd5, 5'd0, 5'd9, 32'h11, 32'h0, 32'h0, 1'b0, 1'b0);
    tick();
    exm_reg_write = 1'b1; exm_rd = 5'd5; exm_result = 32'hAA;
    wb_reg_write = 1'b1; wb_rd = 5'd5; wb_data = 32'hBB;
    #1;
    checks++;
    if (ex_a !== 32'hAA) begin errors++; $display("FAIL fwd_exm_wins got=%h want=aa", ex_a); end
    exm_reg_write = 1'b0;
    #1;
    checks++;
    if (ex_a !== 32'hBB) begin errors++; $display("FAIL fwd_wb got=%h want=bb", ex_a); end
    // x0 source with both producers claiming x0 must read stored data.
    clear_inputs();
    set_id(2'b00, 3'b000, 1'b0, 5'd0, 5'd0, 5'd9, 32'h22, 32'h33, 32'h0, 1'b0, 1'b0);
    tick();
    exm_reg_write = 1'b1; exm_rd = 5'd0; exm_result = 32'hAA;
    wb_reg_write = 1'b1; wb_rd = 5'd0; wb_data = 32'hBB;
    #1;
    checks++;
    if (ex_a !== 32'h22 || ex_store_data !== 32'h33) begin
      errors++; $display("FAIL fwd_x0 a=%h st=%h want 22/33", ex_a, ex_store_data);
    end
    clear_inputs();
  endtask

  task automatic test_load_use();
    set_id(2'b00, 3'b000, 1'b0, 5'd1, 5'd0, 5'd3, 32'd100, 32'd0, 32'd4, 1'b1, 1'b1);
    tick();
    set_id(2'b10, 3'b000, 1'b0, 5'd1, 5'd3, 5'd7, 32'd1, 32'd2, 32'd0, 1'b0, 1'b0);
    #1;
    checks++;
    if (load_use !== 1'b1) begin errors++; $display("FAIL lu_detect got=%b want=1", load_use); end
    tick();
    checks++;
    if (ex_valid !== 1'b0 || ex_alu_ctrl !== 4'b1000 || load_use !== 1'b0) begin
      errors++; $display("FAIL lu_bubble v=%b ctrl=%b lu=%b want 0/1000/0", ex_valid, ex_alu_ctrl, load_use);
    end
    tick();
    checks++;
    if (ex_valid !== 1'b1 || ex_rd !== 5'd7 || ex_alu_ctrl !== 4'b0010) begin
      errors++; $display("FAIL lu_capture v=%b rd=%0d ctrl=%b want 1/7/0010", ex_valid, ex_rd, ex_alu_ctrl);
    end
  endtask

  task automatic test_stall_refresh();
    clear_inputs();
    set_id(2'b00, 3'b000, 1'b0, 5'd4, 5'd0, 5'd8, 32'h99, 32'h0, 32'h0, 1'b0, 1'b0);
    tick();
    stall = 1'b1; id_rs1_data = 32'h5555;
    tick();
    wb_reg_write = 1'b1; wb_rd = 5'd4; wb_data = 32'h1234;
    tick();
    wb_reg_write = 1'b0; wb_rd = 5'd0; wb_data = 32'h0;
    tick();
    stall = 1'b0;
    #1;
    checks++;
    if (ex_a !== 32'h1234 || ex_valid !== 1'b1) begin
      errors++; $display("FAIL stall_refresh a=%h v=%b want 1234/1", ex_a, ex_valid);
    end
  endtask

  task automatic test_flush_stall();
    set_id(2'b10, 3'b111, 1'b0, 5'd1, 5'd2, 5'd5, 32'd1, 32'd2, 32'd0, 1'b0, 1'b0);
    tick();
    stall = 1'b1; flush = 1'b1;
    tick();
    stall = 1'b0; flush = 1'b0;
    checks++;
    if (ex_valid !== 1'b0 || ex_alu_ctrl !== 4'b1000 || ex_reg_write !== 1'b0) begin
      errors++; $display("FAIL flush_stall v=%b ctrl=%b rw=%b want 0/1000/0", ex_valid, ex_alu_ctrl, ex_reg_write);
    end
  endtask

  task automatic test_rst_load_use();
    set_id(2'b00, 3'b000, 1'b0, 5'd1, 5'd0, 5'd3, 32'd0, 32'd0, 32'd8, 1'b1, 1'b1);
    tick();
    set_id(2'b10, 3'b000, 1'b0, 5'd3, 5'd2, 5'd7, 32'd1, 32'd2, 32'd0, 1'b0, 1'b0);
    #1;
    checks++;
    if (load_use !== 1'b1) begin errors++; $display("FAIL rst_lu_pre got=%b want=1", load_use); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    checks++;
    if ({ex_valid, ex_mem_read, ex_reg_write, ex_mem_to_reg, load_use} !== 5'b0 || ex_alu_ctrl !== 4'b1000 || ex_rd !== 5'd0) begin
      errors++; $display("FAIL rst_lu flags=%b ctrl=%b rd=%0d want 0/1000/0",
                         {ex_valid, ex_mem_read, ex_reg_write, ex_mem_to_reg, load_use}, ex_alu_ctrl, ex_rd);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      rst = ($urandom_range(0, 49) == 0);
      stall = ($urandom_range(0, 4) == 0); flush = ($urandom_range(0, 9) == 0);
      id_valid = ($urandom_range(0, 7) != 0);
      id_rs1 = 5'($urandom_range(0, 7)); id_rs2 = 5'($urandom_range(0, 7)); id_rd = 5'($urandom_range(0, 7));
      id_rs1_data = $urandom; id_rs2_data = $urandom; id_imm = $urandom;
      id_alu_op = 2'($urandom_range(0, 3)); id_funct3 = 3'($urandom_range(0, 7));
      id_funct7b5 = 1'($urandom_range(0, 1)); id_alu_src = 1'($urandom_range(0, 1));
      id_reg_write = 1'($urandom_range(0, 1)); id_mem_read = ($urandom_range(0, 2) == 0);
      id_mem_write = 1'($urandom_range(0, 1)); id_mem_to_reg = 1'($urandom_range(0, 1));
      exm_reg_write = 1'($urandom_range(0, 1)); exm_rd = 5'($urandom_range(0, 7)); exm_result = $urandom;
      wb_reg_write = 1'($urandom_range(0, 1)); wb_rd = 5'($urandom_range(0, 7)); wb_data = $urandom;
      #1;
      checks++;
      if (load_use !== model_lu()) begin
        errors++; $display("FAIL rnd_load_use i=%0d got=%b want=%b", i, load_use, model_lu());
      end
      if (m_valid) begin
        checks++;
        if (ex_a !== exp_fwd(m_rs1, m_d1) || ex_store_data !== exp_fwd(m_rs2, m_d2) ||
            ex_b !== (m_src ? m_imm : exp_fwd(m_rs2, m_d2))) begin
          errors++; $display("FAIL rnd_operands i=%0d a=%h b=%h st=%h want a=%h b=%h st=%h", i, ex_a, ex_b,
                             ex_store_data, exp_fwd(m_rs1, m_d1), m_src ? m_imm : exp_fwd(m_rs2, m_d2), exp_fwd(m_rs2, m_d2));
        end
      end
      tick();
      checks++;
      if ({ex_valid, ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg, ex_illegal, ex_alu_ctrl} !==
          {m_valid, m_rw, m_mr, m_mw, m_m2r, m_ill, m_ctrl}) begin
        errors++; $display("FAIL rnd_regs i=%0d got=%b want=%b", i,
                           {ex_valid, ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg, ex_illegal, ex_alu_ctrl},
                           {m_valid, m_rw, m_mr, m_mw, m_m2r, m_ill, m_ctrl});
      end
      if (m_valid) begin
        checks++;
        if (ex_rd !== m_rd) begin errors++; $display("FAIL rnd_rd i=%0d got=%0d want=%0d", i, ex_rd, m_rd); end
      end
    end
    rst = 1'b0; clear_inputs();
  endtask

  initial begin
    m_valid = 1'b0; m_src = 1'b0; m_rw = 1'b0; m_mr = 1'b0; m_mw = 1'b0; m_m2r = 1'b0; m_ill = 1'b0;
    m_rs1 = 5'd0; m_rs2 = 5'd0; m_rd = 5'd0; m_d1 = 32'd0; m_d2 = 32'd0; m_imm = 32'd0; m_ctrl = 4'b1000;
    test_reset();
    test_decode();
    test_forwarding();
    test_load_use();
    test_stall_refresh();
    test_flush_stall();
    test_rst_load_use();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/id_ex_stage.md
# id_ex_stage

ID/EX pipeline stage of the 5-stage RV32I core; sits directly upstream of the ALU and drives its `A`, `B` and 4-bit `ALUcontrol` inputs. It registers decoded instruction fields, generates the ALU control code from `alu_op`/`funct3`/`funct7b5`, and resolves EX/MEM and MEM/WB data hazards through operand forwarding. It also detects load-use hazards and inserts a bubble, and honours external stall/flush from the hazard unit.

## Interface
Parameters:
- `XLEN`, 32: datapath width.
- `REG_AW`, 5: register index width.

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `stall`  in  1  hold all ID/EX registers; has priority over capture and load-use bubble.
- `flush`  in  1  load a bubble; has priority over `stall`.
- `id_valid`  in  1  decode slot holds an instruction.
- `id_rs1`, `id_rs2`  in  REG_AW each  source register indices.
- `id_rs1_data`, `id_rs2_data`  in  XLEN each  register-file read data.
- `id_imm`  in  XLEN  sign-extended immediate.
- `id_rd`  in  REG_AW  destination register index.
- `id_alu_op`  in  2  00 load/store (add), 01 branch (sub), 10 R-type, 11 I-type ALU.
- `id_funct3`  in  3  instruction funct3.
- `id_funct7b5`  in  1  instruction bit 30.
- `id_alu_src`  in  1  1 selects immediate for B.
- `id_reg_write`, `id_mem_read`, `id_mem_write`, `id_mem_to_reg`  in  1 each  control bits.
- `exm_reg_write`  in  1  EX/MEM writes a register.
- `exm_rd`  in  REG_AW  EX/MEM destination index.
- `exm_result`  in  XLEN  EX/MEM ALU result.
- `wb_reg_write`  in  1  MEM/WB writes a register.
- `wb_rd`  in  REG_AW  MEM/WB destination index.
- `wb_data`  in  XLEN  MEM/WB write-back value.
- `load_use`  out  1  combinational; decode must hold this cycle.
- `ex_valid`  out  1  EX slot holds a real instruction.
- `ex_a`, `ex_b`  out  XLEN each  ALU operands after forwarding/select.
- `ex_alu_ctrl`  out  4  to ALU `ALUcontrol`.
- `ex_store_data`  out  XLEN  forwarded rs2 for stores.
- `ex_rd`  out  REG_AW  registered destination index.
- `ex_reg_write`, `ex_mem_read`, `ex_mem_write`, `ex_mem_to_reg`  out  1 each  registered control bits.
- `ex_illegal`  out  1  registered; unsupported ALU operation.

## Operation
- ALU codes: AND 0000, OR 0001, ADD 0010, XOR 0011, SLL 0100, SRL 0101, SUB 0110, SRA 0111, NOP 1000. NOP drives ALU result 0.
- `alu_op` 00 → ADD. `alu_op` 01 → SUB.
- `alu_op` 10, by funct3:
  - 000: SUB if `funct7b5`, else ADD.
  - 001: SLL. 100: XOR. 110: OR. 111: AND.
  - 101: SRA if `funct7b5`, else SRL.
- `alu_op` 11: same as 10, except funct3 000 is always ADD.
- funct3 010/011 (slt/sltu) → NOP with `ex_illegal`=1 (and `ex_valid`=1).
- Control code is decoded in ID and registered; the ALU sees a stable code for the whole EX cycle.
- `load_use` = `ex_valid` & `ex_mem_read` & (`ex_rd`≠0) & (`ex_rd`==`id_rs1` | `ex_rd`==`id_rs2`) & `id_valid`.
- Register update priority per edge:
  1. `rst`: all registers 0.
  2. `flush`: bubble.
  3. `stall`: hold.
  4. `load_use`: bubble.
  5. Otherwise capture ID fields.
- Bubble: `ex_valid`, `ex_reg_write`, `ex_mem_read`, `ex_mem_write`, `ex_mem_to_reg`, `ex_illegal` = 0; `ex_alu_ctrl`=NOP.
- Held-operand refresh: while holding, if `wb_reg_write` & `wb_rd`≠0 & `wb_rd` matches the stored rs1 or rs2 index, overwrite that stored data with `wb_data`. Prevents stale operands after WB retires during a stall.
- Forwarding per source (combinational, from registered index):
  - EX/MEM match (`exm_reg_write`, `exm_rd`≠0, `exm_rd`==rs) → `exm_result`.
  - Else MEM/WB match → `wb_data`.
  - Else stored register-file data.
  - EX/MEM wins when both match; index 0 never forwards.
- `ex_a` = fwd rs1.
- `ex_b` = `ex_alu_src` ? `ex_imm` : fwd rs2.
- `ex_store_data` = fwd rs2, independent of `alu_src`.

## Timing
- Reset: all outputs 0 except `ex_alu_ctrl`=1000. With zero inputs, `ex_a`/`ex_b` read 0.
- Latency: ID fields sampled at edge N appear on `ex_*` in cycle N+1.
- Forwarding is same-cycle combinational on the `exm_*`/`wb_*` inputs.
- `load_use` is valid in the same cycle as the ID fields. It asserts for exactly one cycle per load-use pair unless `stall` is also asserted.
- `flush` and `stall` together: bubble is loaded.
- `rst` mid-stall or mid-load-use: registers clear on the next edge, and `load_use` drops once `ex_valid`=0.

## Structure
- Package `riscv_pkg`:
  - `alu_ctrl_e` (4-bit codes above, shared with the ALU).
  - `alu_op_e` (2-bit).
  - `fwd_sel_e` (REG, WB, EXM).
  - Constant `ALU_NOP`=4'b1000.
- Sub-module `alu_ctrl_dec`: combinational `alu_op`/`funct3`/`funct7b5` → code plus illegal flag. Instantiated once on the ID side.

## Test plan
- Reset, then R-type add with rs1 data 5, rs2 data 7, funct3 000, b5=0 → next cycle `ex_alu_ctrl`=0010, `ex_a`=5, `ex_b`=7, `ex_valid`=1.
- I-type srai with b5=1, imm 3 → `ex_alu_ctrl`=0111, `ex_b`=3. R-type funct3 010 → `ex_alu_ctrl`=1000, `ex_illegal`=1.
- EX inst with rs1=x5; `exm_rd`=5, `exm_result`=0xAA; `wb_rd`=5, `wb_data`=0xBB → `ex_a`=0xAA. Drop `exm_reg_write` → `ex_a`=0xBB. Set rd=0 on both → no forwarding.
- Load to x3 in EX, ID reads rs2=x3 → `load_use`=1 and bubble next cycle (`ex_valid`=0, `ex_alu_ctrl`=1000); dependent instruction is captured on the following edge.
- `stall` for 3 cycles with stored rs1=x4 stale, `wb_rd`=4, `wb_data`=0x1234 in cycle 2 → after release, `ex_a`=0x1234 with no forwarding inputs active.
- `stall`=1 and `flush`=1 together → bubble. `rst` during load-use → all outputs at reset values next cycle.
